// File: rtl/ex_muldiv_pkg.sv
// Shared operation codes, divide/accumulate FSM encodings and decode helpers
// for the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic RstEnable = 1'b1;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [2:0] {
        DIV_STATE_IDLE  = 3'd0,
        DIV_STATE_ACC   = 3'd1,
        DIV_STATE_BUSY  = 3'd2,
        DIV_STATE_DONE  = 3'd3,
        DIV_STATE_DZERO = 3'd4
    } div_state_t;

    // Operations that only write HI/LO and never the GPR file.
    function automatic logic is_hilo_only(input logic [7:0] op);
        case (op)
            EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP, EXE_MADDU_OP,
            EXE_MSUB_OP, EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP: is_hilo_only = 1'b1;
            default:                                             is_hilo_only = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        case (op)
            EXE_MULT_OP, EXE_MUL_OP, EXE_MADD_OP, EXE_MSUB_OP, EXE_DIV_OP: is_signed_op = 1'b1;
            default:                                                       is_signed_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the EX stage control and the mul/div unit.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic [7:0]      aluop_i;
    logic [XLEN-1:0] reg1_i;
    logic [XLEN-1:0] reg2_i;
    logic [4:0]      wd_i;
    logic            wreg_i;
    logic [XLEN-1:0] hi_i;
    logic [XLEN-1:0] lo_i;
    logic            flush_i;
    logic            stallreq_o;
    logic [4:0]      wd_o;
    logic            wreg_o;
    logic [XLEN-1:0] wdata_o;
    logic            whilo_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
        input  stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
        output stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring radix-2 divider: works on operand magnitudes, one quotient bit per
// cycle MSB first, and restores the signs on the way out.
module div_iter
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_flag,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    output logic            ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  divisor_r;
    logic             q_neg_r;
    logic             r_neg_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [XLEN-1:0]  a_mag_s;
    logic [XLEN-1:0]  b_mag_s;
    logic [XLEN:0]    trial_s;
    logic [XLEN:0]    diff_s;

    // Operand magnitudes, trial subtraction and sign-corrected results.
    always_comb begin
        a_neg_s   = signed_flag & a[XLEN-1];
        b_neg_s   = signed_flag & b[XLEN-1];
        a_mag_s   = a_neg_s ? ({XLEN{1'b0}} - a) : a;
        b_mag_s   = b_neg_s ? ({XLEN{1'b0}} - b) : b;
        // Dividend bits are shifted out of the top of quo_r into the remainder.
        trial_s   = {rem_r, quo_r[XLEN-1]};
        diff_s    = trial_s - {1'b0, divisor_r};
        ready     = busy_r & (cnt_r == CNT_W'(XLEN - 1));
        quotient  = q_neg_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
        remainder = r_neg_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
    end

    // Divider iteration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            busy_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            divisor_r <= {XLEN{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (abort) begin
            busy_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (start) begin
            busy_r    <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= a_mag_s;
            divisor_r <= b_mag_s;
            q_neg_r   <= a_neg_s ^ b_neg_s;
            r_neg_r   <= a_neg_s;
        end else if (busy_r) begin
            if (diff_s[XLEN]) begin
                rem_r <= trial_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b0};
            end else begin
                rem_r <= diff_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b1};
            end
            cnt_r <= cnt_r + CNT_W'(1);
            if (ready) begin
                busy_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multiply / multiply-accumulate / divide unit. Plain multiplies
// complete in the issue cycle; accumulate and divide stall the pipeline.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int W2 = 2 * XLEN;

    div_state_t      state_r;
    div_state_t      fsm_next_s;
    div_state_t      state_next_s;
    logic [W2-1:0]   ext_a_s;
    logic [W2-1:0]   ext_b_s;
    logic [W2-1:0]   prod_s;
    logic [W2-1:0]   hilo_s;
    logic [W2-1:0]   acc_s;
    logic [W2-1:0]   mul_r;
    logic            sub_r;
    logic            signed_s;
    logic            acc_load_s;
    logic            sub_req_s;
    logic            start_req_s;
    logic            div_start_s;
    logic            div_ready_s;
    logic [XLEN-1:0] quo_s;
    logic [XLEN-1:0] rem_s;
    logic            stall_s;
    logic            whilo_s;
    logic [XLEN-1:0] hi_s;
    logic [XLEN-1:0] lo_s;
    logic [XLEN-1:0] wdata_s;

    // Full-width product; sign-extending to 2*XLEN makes one multiplier serve both signednesses.
    always_comb begin
        signed_s = is_signed_op(bus.aluop_i);
        ext_a_s  = signed_s ? {{XLEN{bus.reg1_i[XLEN-1]}}, bus.reg1_i} : {{XLEN{1'b0}}, bus.reg1_i};
        ext_b_s  = signed_s ? {{XLEN{bus.reg2_i[XLEN-1]}}, bus.reg2_i} : {{XLEN{1'b0}}, bus.reg2_i};
        prod_s   = ext_a_s * ext_b_s;
        hilo_s   = {bus.hi_i, bus.lo_i};
        acc_s    = sub_r ? (hilo_s - mul_r) : (hilo_s + mul_r);
    end

    // Next-state and unflushed result selection.
    always_comb begin
        fsm_next_s  = state_r;
        stall_s     = 1'b0;
        whilo_s     = 1'b0;
        hi_s        = {XLEN{1'b0}};
        lo_s        = {XLEN{1'b0}};
        wdata_s     = {XLEN{1'b0}};
        acc_load_s  = 1'b0;
        sub_req_s   = 1'b0;
        start_req_s = 1'b0;
        case (state_r)
            DIV_STATE_IDLE: begin
                case (bus.aluop_i)
                    EXE_MULT_OP, EXE_MULTU_OP: begin
                        hi_s    = prod_s[W2-1:XLEN];
                        lo_s    = prod_s[XLEN-1:0];
                        whilo_s = 1'b1;
                    end
                    EXE_MUL_OP: begin
                        wdata_s = prod_s[XLEN-1:0];
                    end
                    EXE_MADD_OP, EXE_MADDU_OP: begin
                        stall_s    = 1'b1;
                        acc_load_s = 1'b1;
                        fsm_next_s = DIV_STATE_ACC;
                    end
                    EXE_MSUB_OP, EXE_MSUBU_OP: begin
                        stall_s    = 1'b1;
                        acc_load_s = 1'b1;
                        sub_req_s  = 1'b1;
                        fsm_next_s = DIV_STATE_ACC;
                    end
                    EXE_DIV_OP, EXE_DIVU_OP: begin
                        stall_s = 1'b1;
                        if (bus.reg2_i == {XLEN{1'b0}}) begin
                            fsm_next_s = DIV_STATE_DZERO;
                        end else begin
                            start_req_s = 1'b1;
                            fsm_next_s  = DIV_STATE_BUSY;
                        end
                    end
                    default: begin
                        fsm_next_s = DIV_STATE_IDLE;
                    end
                endcase
            end
            DIV_STATE_ACC: begin
                hi_s       = acc_s[W2-1:XLEN];
                lo_s       = acc_s[XLEN-1:0];
                whilo_s    = 1'b1;
                fsm_next_s = DIV_STATE_IDLE;
            end
            DIV_STATE_BUSY: begin
                stall_s = 1'b1;
                if (div_ready_s) begin
                    fsm_next_s = DIV_STATE_DONE;
                end else begin
                    fsm_next_s = DIV_STATE_BUSY;
                end
            end
            DIV_STATE_DONE: begin
                hi_s       = rem_s;
                lo_s       = quo_s;
                whilo_s    = 1'b1;
                fsm_next_s = DIV_STATE_IDLE;
            end
            DIV_STATE_DZERO: begin
                whilo_s    = 1'b1;
                fsm_next_s = DIV_STATE_IDLE;
            end
            default: begin
                fsm_next_s = DIV_STATE_IDLE;
            end
        endcase
    end

    assign state_next_s = bus.flush_i ? DIV_STATE_IDLE : fsm_next_s;
    assign div_start_s  = start_req_s & ~bus.flush_i;

    // FSM state plus the product captured for the accumulate cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_r <= DIV_STATE_IDLE;
            mul_r   <= {W2{1'b0}};
            sub_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (acc_load_s) begin
                mul_r <= prod_s;
                sub_r <= sub_req_s;
            end
        end
    end

    div_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start_s),
        .signed_flag (signed_s),
        .a           (bus.reg1_i),
        .b           (bus.reg2_i),
        .abort       (bus.flush_i),
        .ready       (div_ready_s),
        .quotient    (quo_s),
        .remainder   (rem_s)
    );

    // Output stage: reset forces zeros, flush kills every write and the stall.
    always_comb begin
        if (rst == RstEnable) begin
            bus.stallreq_o = 1'b0;
            bus.wd_o       = 5'd0;
            bus.wreg_o     = 1'b0;
            bus.wdata_o    = {XLEN{1'b0}};
            bus.whilo_o    = 1'b0;
            bus.hi_o       = {XLEN{1'b0}};
            bus.lo_o       = {XLEN{1'b0}};
        end else if (bus.flush_i) begin
            bus.stallreq_o = 1'b0;
            bus.wd_o       = bus.wd_i;
            bus.wreg_o     = 1'b0;
            bus.wdata_o    = {XLEN{1'b0}};
            bus.whilo_o    = 1'b0;
            bus.hi_o       = {XLEN{1'b0}};
            bus.lo_o       = {XLEN{1'b0}};
        end else begin
            bus.stallreq_o = stall_s;
            bus.wd_o       = bus.wd_i;
            bus.wreg_o     = bus.wreg_i & ~is_hilo_only(bus.aluop_i);
            bus.wdata_o    = wdata_s;
            bus.whilo_o    = whilo_s;
            bus.hi_o       = hi_s;
            bus.lo_o       = lo_s;
        end
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised execute-stage arithmetic unit for the MIPS pipeline.
- Adds HI/LO-producing operations to the EX stage: MULT, MULTU, MUL, MADD/MADDU, MSUB/MSUBU, DIV and DIVU.
- Multi-cycle operations run under a stall handshake. Results go to the EX/MEM register alongside the existing ALU result.

Parameters:
- XLEN, 32, operand/register width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, width of the divide iteration counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- aluop_i  in  8  operation code (EXE_*_OP from defines)
- reg1_i  in  XLEN  operand A (rs)
- reg2_i  in  XLEN  operand B (rt)
- wd_i  in  5  destination GPR address
- wreg_i  in  1  GPR write request
- hi_i  in  XLEN  current HI, already forwarded
- lo_i  in  XLEN  current LO, already forwarded
- flush_i  in  1  abort the in-flight operation (exception or branch flush)
- stallreq_o  out  1  hold the pipeline at and upstream of EX
- wd_o  out  5  destination GPR address
- wreg_o  out  1  GPR write enable
- wdata_o  out  XLEN  GPR write data (MUL low word)
- whilo_o  out  1  HI/LO write enable
- hi_o  out  XLEN  HI write data
- lo_o  out  XLEN  LO write data

Behaviour:
- Reset: state=IDLE, counter=0, accumulator/temp registers=0. While rst=1 every output is 0.
- Pass-through: wd_o=wd_i at all times. wreg_o=wreg_i, except 0 for all HI/LO-only ops.
- MULT/MULTU/MUL, zero latency (combinational):
  - Full 2*XLEN product; signed for MULT/MUL, unsigned for MULTU.
  - MULT/MULTU: {hi_o,lo_o}=product, whilo_o=1.
  - MUL: wdata_o=product[XLEN-1:0], whilo_o=0.
- MADD/MSUB (signed) and MADDU/MSUBU (unsigned), 2 cycles:
  - Cycle 0 (state IDLE): register the product; stallreq_o=1; go to ACC.
  - Cycle 1 (state ACC): {hi_o,lo_o}={hi_i,lo_i} +/- product (2*XLEN arithmetic, wrap-around); whilo_o=1; stallreq_o=0.
  - Next edge: back to IDLE.
- DIV/DIVU, restoring radix-2. Op issued at cycle T in IDLE:
  - T: stallreq_o=1.
    - If reg2_i==0, go to DZERO.
    - Otherwise latch |A| and |B| (signed: two's-complement magnitude; unsigned: raw), latch the sign flags, counter=0, go to BUSY.
  - T+1..T+XLEN, state BUSY: one quotient bit per cycle, MSB first; counter increments; stallreq_o=1. When counter reaches XLEN-1, go to DONE.
  - T+XLEN+1, state DONE: stallreq_o=0, whilo_o=1.
    - lo_o = quotient, negated if the operand signs differ.
    - hi_o = remainder, carrying the sign of the dividend.
  - Next edge: IDLE.
  - Total stall: XLEN+1 cycles.
- DZERO: lasts one cycle, with stallreq_o=0, whilo_o=1, hi_o=lo_o=0. Then IDLE. No exception is raised.
- Signed overflow case: DIV of the most-negative value by -1 gives lo_o=most-negative, hi_o=0, with no trap.
- flush_i=1 in any state: next state IDLE, whilo_o=0, wreg_o=0, stallreq_o=0 in that cycle. Flush wins over DONE/ACC completion.
- Operand stability: while stallreq_o=1 the upstream holds aluop_i, reg1_i and reg2_i stable. The unit samples operands only in IDLE.
- DONE/ACC/DZERO always return to IDLE, so a back-to-back multi-cycle op re-enters from IDLE on the following cycle.
- Any other aluop_i: stallreq_o=0, whilo_o=0, hi_o=lo_o=wdata_o=0.

Decomposition:
- Shared defines: EXE_MULT/MULTU/MUL/MADD/MADDU/MSUB/MSUBU/DIV/DIVU_OP codes; DIV_STATE_* encodings (IDLE, ACC, BUSY, DONE, DZERO); RstEnable=1'b1.
- Sub-module div_iter: the restoring divide datapath.
  - Inputs: start, signed_flag, a, b, abort.
  - Outputs: ready, quotient, remainder.
- ex_muldiv holds the FSM, the multiplier and the accumulator.

Test Plan:
- MULT: 0xFFFFFFFE (-2) x 0x00000003, XLEN=32 -> whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, stallreq_o=0 in the same cycle. MULTU on the same operands -> hi_o=0x00000002, lo_o=0xFFFFFFFA.
- MADD: HI/LO=0x00000000/0xFFFFFFFF, operands 1 x 1 -> stallreq_o high for exactly 1 cycle; next cycle hi_o=0x00000001, lo_o=0x00000000, whilo_o=1. MSUB from 0/0 with 1 x 1 -> 0xFFFFFFFF/0xFFFFFFFF.
- DIV: -7 / 2 -> stallreq_o high for 33 cycles; then lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). DIVU: 0xFFFFFFFF / 0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF.
- Divide by zero: DIV 5 / 0 -> 1 stall cycle; then hi_o=lo_o=0, whilo_o=1. DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- Abort: flush_i pulsed at BUSY cycle 10 -> next cycle IDLE, whilo_o never asserted; a following DIV 100 / 7 gives lo_o=14, hi_o=2.
- Reset: rst asserted mid-BUSY, asynchronously between clock edges -> all outputs 0 immediately, state IDLE after release. Also repeat with XLEN=16: DIVU 0xFFFF / 3 -> 17 stall cycles, lo_o=0x5555, hi_o=0.
